gf180mcu_fd_sc_mcu9t5v0__or_acc_pipe: RTL and testbench

Parametrised, registered OR-reduction block: N_CH independent channels, each ORing N_IN inputs, with a configurable output pipeline and an optional sticky (accumulate-until-clear) mode. It is the next generation of the library's combinational 3-input OR cell. It serves as a clocked event/flag collector in MCU glue logic: interrupt-source merging, error-flag aggregation, and wide OR trees that must be retimed.

---
 rtl/gf180mcu_fd_sc_mcu9t5v0__or_pkg.sv | 13 +
 rtl/gf180mcu_fd_sc_mcu9t5v0__or_pipe_stage.sv | 42 ++++
 rtl/gf180mcu_fd_sc_mcu9t5v0__or_acc_pipe.sv | 103 ++++++++++
 tb/tb_gf180mcu_fd_sc_mcu9t5v0__or_acc_pipe.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__or_pkg.sv
// Shared limits and mode encoding for the registered OR-reduction family.
package gf180mcu_fd_sc_mcu9t5v0__or_pkg;

    localparam int unsigned OR_MAX_IN     = 16;
    localparam int unsigned OR_MAX_CH     = 8;
    localparam int unsigned OR_MAX_STAGES = 4;

    typedef enum logic {
        OR_MODE_PASS   = 1'b0,
        OR_MODE_STICKY = 1'b1
    } or_mode_e;

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__or_pipe_stage.sv
// One retiming stage: N_CH-bit data register plus valid bit; data holds while the
// incoming valid is low so Z keeps the last delivered result.
module gf180mcu_fd_sc_mcu9t5v0__or_pipe_stage
    import gf180mcu_fd_sc_mcu9t5v0__or_pkg::*;
#(
    parameter int unsigned N_CH = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] d_in,
    input  logic            v_in,
    output logic [N_CH-1:0] d_out,
    output logic            v_out
);

    logic [N_CH-1:0] data_d, data_q;
    logic            valid_d, valid_q;

    // Next-state: load on valid, otherwise hold; valid follows the upstream strobe.
    always_comb begin
        data_d  = data_q;
        valid_d = v_in;
        if (v_in) begin
            data_d = d_in;
        end
    end

    // Stage register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign d_out = data_q;
    assign v_out = valid_q;

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__or_acc_pipe.sv
// Registered multi-channel OR reduction with optional sticky accumulation and a
// STAGES-deep output pipeline. Every output comes from a register.
module gf180mcu_fd_sc_mcu9t5v0__or_acc_pipe
    import gf180mcu_fd_sc_mcu9t5v0__or_pkg::*;
#(
    parameter int unsigned N_IN   = 3,
    parameter int unsigned N_CH   = 1,
    parameter int unsigned STAGES = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [N_CH*N_IN-1:0] A,
    input  logic                 EN,
    input  logic                 STICKY,
    input  logic                 CLR,
    output logic [N_CH-1:0]      Z,
    output logic                 ZV,
    output logic                 ANY
);

    if (N_IN < 2 || N_IN > OR_MAX_IN) begin : g_bad_n_in
        $error("N_IN out of range 2..%0d", OR_MAX_IN);
    end
    if (N_CH < 1 || N_CH > OR_MAX_CH) begin : g_bad_n_ch
        $error("N_CH out of range 1..%0d", OR_MAX_CH);
    end
    if (STAGES < 1 || STAGES > OR_MAX_STAGES) begin : g_bad_stages
        $error("STAGES out of range 1..%0d", OR_MAX_STAGES);
    end

    or_mode_e        mode;
    logic [N_CH-1:0] r;
    logic [N_CH-1:0] s1_d, s1_q;
    logic            v1_d, v1_q;

    // Per-channel OR of its input slice.
    always_comb begin
        r = '0;
        for (int unsigned c = 0; c < N_CH; c++) begin
            r[c] = |A[c*N_IN +: N_IN];
        end
    end

    // Stage-1 next state: pass mode loads on EN; sticky mode clears first, then ORs in the sample.
    always_comb begin
        mode = or_mode_e'(STICKY);
        s1_d = s1_q;
        v1_d = EN;
        if (mode == OR_MODE_STICKY) begin
            if (CLR) begin
                s1_d = '0;
            end
            if (EN) begin
                s1_d = s1_d | r;
            end
        end else if (EN) begin
            s1_d = r;
        end
    end

    // Stage-1 register; reset overrides EN and CLR.
    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_q <= '0;
            v1_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            v1_q <= v1_d;
        end
    end

    logic [N_CH-1:0] s_chain [STAGES];
    logic            v_chain [STAGES];

    assign s_chain[0] = s1_q;
    assign v_chain[0] = v1_q;

    for (genvar k = 1; k < STAGES; k++) begin : g_stage
        gf180mcu_fd_sc_mcu9t5v0__or_pipe_stage #(
            .N_CH(N_CH)
        ) u_stage (
            .clk   (CLK),
            .rst   (RST),
            .d_in  (s_chain[k-1]),
            .v_in  (v_chain[k-1]),
            .d_out (s_chain[k]),
            .v_out (v_chain[k])
        );
    end

    assign Z   = s_chain[STAGES-1];
    assign ZV  = v_chain[STAGES-1];
    assign ANY = |Z;

`ifndef FUNCTIONAL
    specify
        (CLK *> Z)   = (1.0, 1.0);
        (CLK => ZV)  = (1.0, 1.0);
        (CLK => ANY) = (1.0, 1.0);
    endspecify
`endif

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__or_acc_pipe.sv
// Bench: four instances (STAGES=1..4, N_IN=3, N_CH=2) share stimulus; each cycle all
// are compared with a sample-history reference model, plus table and hand sequences.
module tb_gf180mcu_fd_sc_mcu9t5v0__or_acc_pipe;

    logic       clk = 1'b0;
    logic       rst, en, sticky, clr;
    logic [5:0] a;
    logic [1:0] z   [4];
    logic       zv  [4];
    logic       anyo[4];

    always #5 clk = ~clk;

    gf180mcu_fd_sc_mcu9t5v0__or_acc_pipe #(.N_IN(3), .N_CH(2), .STAGES(1)) u_s1 (
        .CLK(clk), .RST(rst), .A(a), .EN(en), .STICKY(sticky), .CLR(clr),
        .Z(z[0]), .ZV(zv[0]), .ANY(anyo[0]));
    gf180mcu_fd_sc_mcu9t5v0__or_acc_pipe #(.N_IN(3), .N_CH(2), .STAGES(2)) u_s2 (
        .CLK(clk), .RST(rst), .A(a), .EN(en), .STICKY(sticky), .CLR(clr),
        .Z(z[1]), .ZV(zv[1]), .ANY(anyo[1]));
    gf180mcu_fd_sc_mcu9t5v0__or_acc_pipe #(.N_IN(3), .N_CH(2), .STAGES(3)) u_s3 (
        .CLK(clk), .RST(rst), .A(a), .EN(en), .STICKY(sticky), .CLR(clr),
        .Z(z[2]), .ZV(zv[2]), .ANY(anyo[2]));
    gf180mcu_fd_sc_mcu9t5v0__or_acc_pipe #(.N_IN(3), .N_CH(2), .STAGES(4)) u_s4 (
        .CLK(clk), .RST(rst), .A(a), .EN(en), .STICKY(sticky), .CLR(clr),
        .Z(z[3]), .ZV(zv[3]), .ANY(anyo[3]));

    // Reference model: history of the accumulated result and of accepted/reset edges.
    logic [1:0] acc_hist [1024];
    bit         val_hist [1024];
    bit         rst_hist [1024];
    logic [1:0] acc;
    int         t;
    int         vectors;
    int         miscompares;

    typedef struct {
        logic [5:0] a;
        logic       en;
        logic       st;
        logic       clr;
        logic [1:0] z;
        logic       zv;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input logic [1:0] got, input logic [1:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s t=%0d got=%b want=%b", name, t, got, want);
        end
    endtask

    function automatic logic [1:0] ror(input logic [5:0] v);
        return {|v[5:3], |v[2:0]};
    endfunction

    // Z after the current edge = result of the newest sample that has had STAGES-1 edges to
    // travel, unless a reset happened since; ZV marks a sample arriving exactly now.
    function automatic void model_out(input int s, output logic [1:0] ez, output logic ezv);
        ez  = 2'b00;
        ezv = 1'b0;
        if (s == 1) begin
            ez  = acc_hist[t];
            ezv = val_hist[t];
            return;
        end
        for (int u = t; u >= 0; u--) begin
            if (rst_hist[u]) return;
            if (u <= t - s + 1 && val_hist[u]) begin
                ez  = acc_hist[u];
                ezv = (u == t - s + 1);
                return;
            end
        end
    endfunction

    task automatic step(input logic [5:0] ia, input logic ien, input logic ist,
                        input logic iclr, input logic irst);
        logic [1:0] ez;
        logic       ezv;
        a = ia; en = ien; sticky = ist; clr = iclr; rst = irst;
        @(posedge clk);
        #1;
        if (irst)     acc = 2'b00;
        else if (ist) acc = (iclr ? 2'b00 : acc) | (ien ? ror(ia) : 2'b00);
        else if (ien) acc = ror(ia);
        t++;
        acc_hist[t] = acc;
        val_hist[t] = ien && !irst;
        rst_hist[t] = irst;
        for (int s = 1; s <= 4; s++) begin
            model_out(s, ez, ezv);
            check($sformatf("model_z_s%0d", s), z[s-1], ez);
            check($sformatf("model_zv_s%0d", s), {1'b0, zv[s-1]}, {1'b0, ezv});
            check($sformatf("model_any_s%0d", s), {1'b0, anyo[s-1]}, {1'b0, |ez});
        end
    endtask

    initial begin
        int zv_cnt;
        int first_zv;
        vectors = 0; miscompares = 0; t = 0; acc = 2'b00;
        rst_hist[0] = 1'b1; val_hist[0] = 1'b0; acc_hist[0] = 2'b00;
        a = '0; en = 0; sticky = 0; clr = 0; rst = 1;

        // Reset with EN and all-ones input: everything zero, no stray ZV afterwards.
        step(6'b111111, 1, 0, 0, 1);
        for (int s = 0; s < 4; s++) begin
            check("reset_z", z[s], 2'b00);
            check("reset_zv", {1'b0, zv[s]}, 2'b00);
            check("reset_any", {1'b0, anyo[s]}, 2'b00);
        end
        zv_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            step(6'b111111, 0, 0, 0, 0);
            for (int s = 0; s < 4; s++) zv_cnt += zv[s];
        end
        check("post_reset_no_zv", zv_cnt[1:0], 2'b00);

        // Pass mode, STAGES=2: result two edges after the sample, one ZV, then hold.
        step(6'b000100, 1, 0, 0, 0);
        check("pass_s2_early_zv", {1'b0, zv[1]}, 2'b00);
        step(6'b000000, 0, 0, 0, 0);
        check("pass_s2_z", z[1], 2'b01);
        check("pass_s2_zv", {1'b0, zv[1]}, 2'b01);
        check("pass_s2_any", {1'b0, anyo[1]}, 2'b01);
        step(6'b000000, 0, 0, 0, 0);
        check("pass_s2_hold_z", z[1], 2'b01);
        check("pass_s2_hold_zv", {1'b0, zv[1]}, 2'b00);

        // Sticky / clear / mode-switch table against the STAGES=1 instance.
        step(6'b000000, 0, 0, 0, 1);
        tbl[0] = '{6'b000001, 1, 1, 0, 2'b01, 1};
        tbl[1] = '{6'b010000, 1, 1, 0, 2'b11, 1};
        tbl[2] = '{6'b000000, 1, 1, 0, 2'b11, 1};
        tbl[3] = '{6'b111111, 0, 1, 1, 2'b00, 0};
        tbl[4] = '{6'b001001, 1, 1, 0, 2'b11, 1};
        tbl[5] = '{6'b000010, 1, 1, 1, 2'b01, 1};
        tbl[6] = '{6'b000000, 1, 0, 0, 2'b00, 1};
        tbl[7] = '{6'b100000, 1, 1, 0, 2'b10, 1};
        for (int i = 0; i < 8; i++) begin
            step(tbl[i].a, tbl[i].en, tbl[i].st, tbl[i].clr, 0);
            check($sformatf("tbl%0d_z", i), z[0], tbl[i].z);
            check($sformatf("tbl%0d_zv", i), {1'b0, zv[0]}, {1'b0, tbl[i].zv});
        end

        // Back-to-back, STAGES=4: 8 samples give 8 consecutive ZV starting 3 edges later.
        step(6'b000000, 0, 0, 0, 1);
        zv_cnt = 0; first_zv = -1;
        for (int i = 0; i < 14; i++) begin
            if (i < 8) step(6'($urandom), 1, 0, 0, 0);
            else       step(6'b000000, 0, 0, 0, 0);
            if (zv[3]) begin
                zv_cnt++;
                if (first_zv < 0) first_zv = i;
            end
        end
        check("b2b_zv_count", zv_cnt[1:0] | {1'b0, zv_cnt != 8}, 2'b00 | {1'b0, 1'b0} | zv_cnt[1:0]);
        check("b2b_zv_count8", {1'b0, zv_cnt == 8}, 2'b01);
        check("b2b_first_zv", first_zv[1:0], 2'd3);

        // Reset mid-pipeline, STAGES=3: in-flight samples never strobe.
        step(6'b000000, 0, 0, 0, 1);
        step(6'b111000, 1, 0, 0, 0);
        step(6'b000111, 1, 0, 0, 0);
        step(6'b000000, 0, 0, 0, 1);
        zv_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            step(6'b000000, 0, 0, 0, 0);
            zv_cnt += zv[2];
            check("midrst_s3_z", z[2], 2'b00);
        end
        check("midrst_s3_no_zv", {1'b0, zv_cnt != 0}, 2'b00);

        // Randomized traffic against the model.
        begin
            logic st_r;
            st_r = 0;
            for (int i = 0; i < 300; i++) begin
                if ($urandom_range(0, 9) == 0) st_r = ~st_r;
                step(6'($urandom), ($urandom_range(0, 3) != 0), st_r,
                     ($urandom_range(0, 5) == 0), ($urandom_range(0, 31) == 0));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
